// File: rtl/csr_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_rmw_unit
// Brief    : Zicsr read-modify-write sequencer (CSRRW/CSRRS/CSRRC and imm
//            forms). Reads the old CSR value, computes the new value, writes
//            it back to the CSR file and returns the old value to execute.
//            Writes to read-only CSRs and reserved ops are flagged illegal.
// Revision : 1.0 - initial release
// ============================================================================
module csr_rmw_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,          // synchronous, active-low
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_src,
    input  logic              req_src_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_illegal,
    output logic              csr_write_en,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_in,
    input  logic [XLEN-1:0]   csr_out
);

    // Op encodings
    localparam logic [1:0] c_OP_RSVD = 2'b00;
    localparam logic [1:0] c_OP_RW   = 2'b01;
    localparam logic [1:0] c_OP_RS   = 2'b10;
    localparam logic [1:0] c_OP_RC   = 2'b11;

    // FSM state encodings
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_READ  = 2'd1;
    localparam logic [1:0] c_S_WRITE = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_src;
    logic              r_src_zero;
    logic [XLEN-1:0]   r_old;
    logic              r_illegal;

    logic              w_wr_intent;
    logic              w_illegal;
    logic              w_read_only;
    logic [XLEN-1:0]   w_new_val;

    // Decode write intent, illegality and the modified value from latched request
    always_comb begin
        w_wr_intent = (r_op == c_OP_RW) |
                      (((r_op == c_OP_RS) | (r_op == c_OP_RC)) & ~r_src_zero);
        // Top two address bits 2'b11 mark the read-only CSR space
        w_read_only = (r_addr[ADDR_W-1:ADDR_W-2] == 2'b11);
        w_illegal   = (r_op == c_OP_RSVD) | (w_read_only & w_wr_intent);
        case (r_op)
            c_OP_RW: w_new_val = r_src;
            c_OP_RS: w_new_val = r_old | r_src;
            c_OP_RC: w_new_val = r_old & ~r_src;
            default: w_new_val = '0;
        endcase
    end

    // Sequencer: IDLE -> READ -> WRITE -> RESP -> IDLE, one op at a time
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_S_IDLE;
            r_op       <= '0;
            r_addr     <= '0;
            r_src      <= '0;
            r_src_zero <= 1'b0;
            r_old      <= '0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (req_valid) begin
                        r_op       <= req_op;
                        r_addr     <= req_addr;
                        r_src      <= req_src;
                        r_src_zero <= req_src_zero;
                        r_state    <= c_S_READ;
                    end
                end
                c_S_READ: begin
                    r_old     <= csr_out;
                    r_illegal <= w_illegal;
                    r_state   <= c_S_WRITE;
                end
                c_S_WRITE: begin
                    // Always proceed to the response, even when no write is issued
                    r_state <= c_S_RESP;
                end
                c_S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Output decode from state; reset level gates every handshake and the write strobe
    always_comb begin
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_data     = '0;
        rsp_illegal  = 1'b0;
        csr_write_en = 1'b0;
        csr_addr     = '0;
        csr_in       = '0;
        if (rst) begin
            case (r_state)
                c_S_IDLE: begin
                    req_ready = 1'b1;
                end
                c_S_READ: begin
                    csr_addr = r_addr;
                end
                c_S_WRITE: begin
                    csr_addr     = r_addr;
                    csr_write_en = w_wr_intent & ~r_illegal;
                    csr_in       = (w_wr_intent & ~r_illegal) ? w_new_val : '0;
                end
                c_S_RESP: begin
                    rsp_valid   = 1'b1;
                    rsp_data    = r_old;
                    rsp_illegal = r_illegal;
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
